// File: rtl/parent_call_port.sv
`timescale 1ns/1ps
// parent_call_port
//
// Parent-side port that lets several hardware threads call child functions
// through a shared arbiter and collect their return values.
//
// Call path: an accepted call is packed into a one-entry command register
// and written to the arbiter whenever its slot is free. A call that expects
// a return value is recorded in a per-thread pending table.
//
// Return path: words from the return FIFO are matched by child index
// against the pending table and handed back to the owning thread.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   call_vld_i / call_rdy_o   call handshake
//   call_thread_i             issuing thread
//   call_child_i              target child function
//   call_ret_i                caller expects a return value
//   call_pc_i, call_args_i    caller pc and packed arguments
//   cmd_din_o, cmd_write_o    command word and write strobe to the arbiter
//   cmd_full_n_i              arbiter command slot free
//   ret_empty_n_i, ret_dout_i return FIFO status and head word {child, data}
//   ret_pop_o                 return FIFO pop
//   ret_vld_o / ret_rdy_i     return delivery handshake to the parent
//   ret_thread_o, ret_data_o  delivered thread and return value
//   pend_o                    per-thread outstanding-return flags
//   err_o                     sticky flag: a return arrived with no caller
module parent_call_port #(
  parameter int THREAD  = 4,
  parameter int CHILD   = 64,
  parameter int ARG_W   = 32,
  parameter int ARG_NUM = 4,
  localparam int LOG_THREAD = (THREAD > 1) ? $clog2(THREAD) : 1,
  localparam int LOG_CHILD  = (CHILD > 1) ? $clog2(CHILD) : 1,
  localparam int RET_DW     = 32,
  localparam int CMD_DW     = ARG_W*ARG_NUM + LOG_THREAD + LOG_CHILD + 1 + 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         call_vld_i,
  output logic                         call_rdy_o,
  input  logic [LOG_THREAD-1:0]        call_thread_i,
  input  logic [LOG_CHILD-1:0]         call_child_i,
  input  logic                         call_ret_i,
  input  logic [31:0]                  call_pc_i,
  input  logic [ARG_NUM*ARG_W-1:0]     call_args_i,
  output logic [CMD_DW-1:0]            cmd_din_o,
  output logic                         cmd_write_o,
  input  logic                         cmd_full_n_i,
  input  logic                         ret_empty_n_i,
  input  logic [RET_DW+LOG_CHILD-1:0]  ret_dout_i,
  output logic                         ret_pop_o,
  output logic                         ret_vld_o,
  input  logic                         ret_rdy_i,
  output logic [LOG_THREAD-1:0]        ret_thread_o,
  output logic [31:0]                  ret_data_o,
  output logic [THREAD-1:0]            pend_o,
  output logic                         err_o
);

  // Command register
  logic                  cmd_vld;
  logic [CMD_DW-1:0]     cmd_data;

  // Pending table: one outstanding return per thread
  logic [THREAD-1:0]     pend;
  logic [LOG_CHILD-1:0]  pend_child [THREAD];

  // Return register
  logic                  ret_vld;
  logic [LOG_THREAD-1:0] ret_thread;
  logic [31:0]           ret_data;
  logic                  err;

  // Handshake and matching helpers
  logic                  hazard;
  logic                  call_fire;
  logic                  deliver;
  logic [LOG_CHILD-1:0]  pop_child;
  logic [31:0]           pop_data;
  logic                  match_hit;
  logic [LOG_THREAD-1:0] match_thread;

  // A call that expects a return is blocked while its own thread still waits
  // for a return, or while any other thread waits on the same child; either
  // case would make the returned word ambiguous. Only registered pend state
  // is consulted, so a return cleared this cycle unblocks the call next cycle.
  always_comb begin
    hazard = 1'b0;
    for (int t = 0; t < THREAD; t++) begin
      if (pend[t] && ((t[LOG_THREAD-1:0] == call_thread_i) ||
                      (pend_child[t] == call_child_i))) begin
        hazard = 1'b1;
      end
    end
    if (!call_ret_i) begin
      hazard = 1'b0;
    end
  end

  // Split the FIFO head word and find the thread that is waiting on that
  // child. The hazard rule keeps at most one pending thread per child, so the
  // first hit is the only hit.
  assign pop_child = ret_dout_i[RET_DW +: LOG_CHILD];
  assign pop_data  = ret_dout_i[RET_DW-1:0];

  always_comb begin
    match_hit    = 1'b0;
    match_thread = '0;
    for (int t = 0; t < THREAD; t++) begin
      if (!match_hit && pend[t] && (pend_child[t] == pop_child)) begin
        match_hit    = 1'b1;
        match_thread = t[LOG_THREAD-1:0];
      end
    end
  end

  // Handshakes. The command register may take a new call whenever it is empty
  // or is being drained this cycle, which gives one call per cycle when the
  // arbiter never stalls. Ready and pop are forced low during reset.
  assign call_rdy_o  = ~rst & (~cmd_vld | cmd_full_n_i) & ~hazard;
  assign call_fire   = call_vld_i & call_rdy_o;
  assign cmd_write_o = cmd_vld & cmd_full_n_i;
  assign ret_pop_o   = ~rst & ret_empty_n_i & (~ret_vld | ret_rdy_i);
  assign deliver     = ret_vld & ret_rdy_i;

  // Command register: load on an accepted call (which wins over a drain in the
  // same cycle), otherwise empty once the arbiter takes the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_vld  <= 1'b0;
      cmd_data <= '0;
    end else if (call_fire) begin
      cmd_vld  <= 1'b1;
      cmd_data <= {call_pc_i, call_ret_i, call_child_i, call_thread_i, call_args_i};
    end else if (cmd_write_o) begin
      cmd_vld  <= 1'b0;
    end
  end

  // Pending table: a thread's entry clears when its return is delivered and
  // is set by an accepted call that expects a return. The hazard rule stops
  // both from hitting the same thread in one cycle, so the order here only
  // matters for different threads, where both updates take effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      for (int t = 0; t < THREAD; t++) begin
        pend_child[t] <= '0;
      end
    end else begin
      for (int t = 0; t < THREAD; t++) begin
        if (deliver && (ret_thread == t[LOG_THREAD-1:0])) begin
          pend[t] <= 1'b0;
        end
        if (call_fire && call_ret_i && (call_thread_i == t[LOG_THREAD-1:0])) begin
          pend[t]       <= 1'b1;
          pend_child[t] <= call_child_i;
        end
      end
    end
  end

  // Return register: a popped word that matches a pending thread is loaded
  // and presented from the next cycle. This may coincide with the delivery of
  // the previous word, in which case valid stays high. An unmatched word is
  // dropped and raises the sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_vld    <= 1'b0;
      ret_thread <= '0;
      ret_data   <= '0;
      err        <= 1'b0;
    end else begin
      if (ret_pop_o && match_hit) begin
        ret_vld    <= 1'b1;
        ret_thread <= match_thread;
        ret_data   <= pop_data;
      end else if (deliver) begin
        ret_vld    <= 1'b0;
      end
      if (ret_pop_o && !match_hit) begin
        err <= 1'b1;
      end
    end
  end

  assign cmd_din_o    = cmd_data;
  assign ret_vld_o    = ret_vld;
  assign ret_thread_o = ret_thread;
  assign ret_data_o   = ret_data;
  assign pend_o       = pend;
  assign err_o        = err;

endmodule

// File: tb/tb_parent_call_port.sv
`timescale 1ns/1ps
// tb_parent_call_port
//
// Directed bench for parent_call_port with default parameters. A queue-based
// model of the port (command queue, per-thread pending child, return queue)
// predicts every output on every falling edge; directed literal checks pin
// the model to hand-computed values for the key scenarios.
module tb_parent_call_port;

  localparam int THREAD = 4;
  localparam int CHILD  = 64;
  localparam int ARG_W  = 32;
  localparam int ARG_NUM = 4;
  localparam int LT     = 2;
  localparam int LC     = 6;
  localparam int CMD_DW = ARG_W*ARG_NUM + LT + LC + 1 + 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 call_vld_i = 1'b0;
  logic                 call_rdy_o;
  logic [LT-1:0]        call_thread_i = '0;
  logic [LC-1:0]        call_child_i = '0;
  logic                 call_ret_i = 1'b0;
  logic [31:0]          call_pc_i = '0;
  logic [127:0]         call_args_i = '0;
  logic [CMD_DW-1:0]    cmd_din_o;
  logic                 cmd_write_o;
  logic                 cmd_full_n_i = 1'b1;
  logic                 ret_empty_n_i = 1'b0;
  logic [32+LC-1:0]     ret_dout_i = '0;
  logic                 ret_pop_o;
  logic                 ret_vld_o;
  logic                 ret_rdy_i = 1'b0;
  logic [LT-1:0]        ret_thread_o;
  logic [31:0]          ret_data_o;
  logic [THREAD-1:0]    pend_o;
  logic                 err_o;

  parent_call_port #(
    .THREAD(THREAD), .CHILD(CHILD), .ARG_W(ARG_W), .ARG_NUM(ARG_NUM)
  ) dut (
    .clk(clk), .rst(rst),
    .call_vld_i(call_vld_i), .call_rdy_o(call_rdy_o),
    .call_thread_i(call_thread_i), .call_child_i(call_child_i),
    .call_ret_i(call_ret_i), .call_pc_i(call_pc_i), .call_args_i(call_args_i),
    .cmd_din_o(cmd_din_o), .cmd_write_o(cmd_write_o), .cmd_full_n_i(cmd_full_n_i),
    .ret_empty_n_i(ret_empty_n_i), .ret_dout_i(ret_dout_i), .ret_pop_o(ret_pop_o),
    .ret_vld_o(ret_vld_o), .ret_rdy_i(ret_rdy_i),
    .ret_thread_o(ret_thread_o), .ret_data_o(ret_data_o),
    .pend_o(pend_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // One comparison: count it, and report it when actual differs from expected.
  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model state: words waiting for the arbiter, child each thread waits on
  // (-1 when none), returns waiting for the parent, and the sticky error.
  logic [CMD_DW-1:0] m_cmd_q[$];
  int                m_pend[THREAD];
  int                m_ret_thr[$];
  logic [31:0]       m_ret_dat[$];
  bit                m_err;

  function automatic bit modelHazard();
    bit h;
    h = 1'b0;
    if (call_ret_i) begin
      if (m_pend[call_thread_i] >= 0) h = 1'b1;
      for (int t = 0; t < THREAD; t++)
        if (m_pend[t] == int'(call_child_i)) h = 1'b1;
    end
    return h;
  endfunction

  // Compare process: check all outputs against the model on every falling
  // edge, then advance the model by the transfers that the coming rising edge
  // will perform.
  always @(negedge clk) begin
    bit exp_rdy, exp_wr, exp_pop, dlv, acc;
    int hit;
    logic [THREAD-1:0] exp_pend;
    if (rst) begin
      checkOutput("rst_call_rdy", call_rdy_o, 0);
      checkOutput("rst_cmd_write", cmd_write_o, 0);
      checkOutput("rst_ret_pop", ret_pop_o, 0);
      checkOutput("rst_ret_vld", ret_vld_o, 0);
      checkOutput("rst_pend", pend_o, 0);
      checkOutput("rst_err", err_o, 0);
      m_cmd_q.delete();
      m_ret_thr.delete();
      m_ret_dat.delete();
      for (int t = 0; t < THREAD; t++) m_pend[t] = -1;
      m_err = 1'b0;
    end else begin
      exp_wr  = (m_cmd_q.size() != 0) && cmd_full_n_i;
      exp_rdy = ((m_cmd_q.size() == 0) || cmd_full_n_i) && !modelHazard();
      exp_pop = ret_empty_n_i && ((m_ret_thr.size() == 0) || ret_rdy_i);
      exp_pend = '0;
      for (int t = 0; t < THREAD; t++) exp_pend[t] = (m_pend[t] >= 0);
      checkOutput("call_rdy", call_rdy_o, exp_rdy);
      checkOutput("cmd_write", cmd_write_o, exp_wr);
      if (exp_wr) checkOutput("cmd_din", cmd_din_o, m_cmd_q[0]);
      checkOutput("ret_pop", ret_pop_o, exp_pop);
      checkOutput("ret_vld", ret_vld_o, m_ret_thr.size() != 0);
      if (m_ret_thr.size() != 0) begin
        checkOutput("ret_thread", ret_thread_o, m_ret_thr[0]);
        checkOutput("ret_data", ret_data_o, m_ret_dat[0]);
      end
      checkOutput("pend", pend_o, exp_pend);
      checkOutput("err", err_o, m_err);

      dlv = (m_ret_thr.size() != 0) && ret_rdy_i;
      acc = call_vld_i && exp_rdy;
      hit = -1;
      if (exp_pop)
        for (int t = 0; t < THREAD; t++)
          if (m_pend[t] == int'(ret_dout_i[37:32])) hit = t;
      if (dlv) begin
        m_pend[m_ret_thr[0]] = -1;
        void'(m_ret_thr.pop_front());
        void'(m_ret_dat.pop_front());
      end
      if (exp_wr) void'(m_cmd_q.pop_front());
      if (acc) begin
        m_cmd_q.push_back({call_pc_i, call_ret_i, call_child_i, call_thread_i, call_args_i});
        if (call_ret_i) m_pend[call_thread_i] = int'(call_child_i);
      end
      if (exp_pop) begin
        if (hit >= 0) begin
          m_ret_thr.push_back(hit);
          m_ret_dat.push_back(ret_dout_i[31:0]);
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit vld, input int thr, input int chl, input bit ret,
                               input logic [31:0] pc, input logic [127:0] args);
    call_vld_i    = vld;
    call_thread_i = thr[LT-1:0];
    call_child_i  = chl[LC-1:0];
    call_ret_i    = ret;
    call_pc_i     = pc;
    call_args_i   = args;
  endtask

  task automatic applyReturn(input bit vld, input int chl, input logic [31:0] data, input bit rdy);
    ret_empty_n_i = vld;
    ret_dout_i    = {chl[LC-1:0], data};
    ret_rdy_i     = rdy;
  endtask

  localparam logic [127:0] ARGS_A = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] ARGS_B = 128'hBBBBBBBB_BBBBBBBB_BBBBBBBB_BBBBBBBB;
  localparam logic [127:0] ARGS_C = 128'h0000000C_0000000C_0000000C_0000000C;

  initial begin
    // Reset with activity on the inputs: nothing may be accepted or popped.
    applyStimulus(1, 1, 5, 1, 32'h100, ARGS_A);
    applyReturn(1, 9, 32'h0, 1);
    #2;
    checkOutput("reset_call_rdy", call_rdy_o, 0);
    checkOutput("reset_ret_pop", ret_pop_o, 0);
    checkOutput("reset_pend", pend_o, 0);
    repeat (3) tick();

    // First call accepted in the first cycle after reset release.
    rst = 1'b0;
    applyReturn(0, 0, 32'h0, 0);
    #1;
    checkOutput("first_call_rdy", call_rdy_o, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h0, '0);
    #1;
    checkOutput("first_cmd_write", cmd_write_o, 1);
    checkOutput("first_cmd_din", cmd_din_o, {32'h0000_0100, 1'b1, 6'd5, 2'd1, ARGS_A});
    checkOutput("first_pend", pend_o, 4'b0010);
    tick();
    #1;
    checkOutput("first_cmd_idle", cmd_write_o, 0);

    // Arbiter stall for three cycles with two calls offered.
    cmd_full_n_i = 1'b0;
    applyStimulus(1, 2, 7, 0, 32'h200, ARGS_B);
    #1;
    checkOutput("stall_first_rdy", call_rdy_o, 1);
    tick();
    applyStimulus(1, 3, 8, 0, 32'h300, ARGS_C);
    #1;
    checkOutput("stall_rdy_low", call_rdy_o, 0);
    checkOutput("stall_no_write", cmd_write_o, 0);
    tick();
    #1;
    checkOutput("stall_rdy_low2", call_rdy_o, 0);
    tick();
    cmd_full_n_i = 1'b1;
    #1;
    checkOutput("release_write_a", cmd_write_o, 1);
    checkOutput("release_din_a", cmd_din_o, {32'h0000_0200, 1'b0, 6'd7, 2'd2, ARGS_B});
    checkOutput("release_rdy_b", call_rdy_o, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h0, '0);
    #1;
    checkOutput("release_write_b", cmd_write_o, 1);
    checkOutput("release_din_b", cmd_din_o, {32'h0000_0300, 1'b0, 6'd8, 2'd3, ARGS_C});
    tick();

    // Retire thread 1's return on child 5.
    applyReturn(1, 5, 32'h1111_2222, 1);
    #1;
    checkOutput("t1_pop", ret_pop_o, 1);
    tick();
    applyReturn(0, 0, 32'h0, 1);
    #1;
    checkOutput("t1_ret_vld", ret_vld_o, 1);
    checkOutput("t1_ret_thread", ret_thread_o, 1);
    checkOutput("t1_ret_data", ret_data_o, 32'h1111_2222);
    tick();
    #1;
    checkOutput("t1_pend_clear", pend_o, 4'b0000);

    // Thread 0 waits on child 5; thread 2 calling child 5 is held back.
    applyStimulus(1, 0, 5, 1, 32'h400, ARGS_A);
    applyReturn(0, 0, 32'h0, 0);
    tick();
    applyStimulus(1, 2, 5, 1, 32'h500, ARGS_B);
    #1;
    checkOutput("haz_pend", pend_o, 4'b0001);
    checkOutput("haz_rdy_low", call_rdy_o, 0);
    tick();
    applyReturn(1, 5, 32'hDEAD_BEEF, 0);
    #1;
    checkOutput("haz_pop", ret_pop_o, 1);
    tick();
    applyReturn(0, 0, 32'h0, 0);
    #1;
    checkOutput("hold_vld", ret_vld_o, 1);
    checkOutput("hold_thread", ret_thread_o, 0);
    checkOutput("hold_data", ret_data_o, 32'hDEAD_BEEF);
    checkOutput("hold_rdy_low", call_rdy_o, 0);
    tick();
    #1;
    checkOutput("hold_data2", ret_data_o, 32'hDEAD_BEEF);
    tick();
    ret_rdy_i = 1'b1;
    #1;
    checkOutput("deliver_rdy_still_low", call_rdy_o, 0);
    tick();
    #1;
    checkOutput("after_deliver_rdy", call_rdy_o, 1);
    checkOutput("after_deliver_pend", pend_o, 4'b0000);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h0, '0);
    #1;
    checkOutput("t2_pend", pend_o, 4'b0100);

    // Delivery and a new pop in the same cycle.
    applyStimulus(1, 3, 6, 1, 32'h600, ARGS_C);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h0, '0);
    applyReturn(1, 5, 32'hCAFE_0002, 0);
    tick();
    applyReturn(1, 6, 32'hCAFE_0003, 1);
    #1;
    checkOutput("overlap_thread_a", ret_thread_o, 2);
    checkOutput("overlap_pop", ret_pop_o, 1);
    tick();
    applyReturn(0, 0, 32'h0, 1);
    #1;
    checkOutput("overlap_vld", ret_vld_o, 1);
    checkOutput("overlap_thread_b", ret_thread_o, 3);
    checkOutput("overlap_data_b", ret_data_o, 32'hCAFE_0003);
    checkOutput("overlap_pend", pend_o, 4'b1000);
    tick();

    // Unmatched return: popped, dropped, sticky error.
    applyReturn(1, 9, 32'h9999_9999, 1);
    #1;
    checkOutput("orphan_pop", ret_pop_o, 1);
    tick();
    applyReturn(0, 0, 32'h0, 1);
    #1;
    checkOutput("orphan_err", err_o, 1);
    checkOutput("orphan_no_vld", ret_vld_o, 0);
    tick();
    tick();
    #1;
    checkOutput("orphan_err_sticky", err_o, 1);

    // Reset while a return is presented and threads 0 and 2 are pending.
    applyStimulus(1, 0, 1, 1, 32'h700, ARGS_A);
    tick();
    applyStimulus(1, 2, 2, 1, 32'h800, ARGS_B);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h0, '0);
    applyReturn(1, 1, 32'h1234_5678, 0);
    tick();
    applyReturn(0, 0, 32'h0, 0);
    #1;
    checkOutput("pre_rst_vld", ret_vld_o, 1);
    checkOutput("pre_rst_pend", pend_o, 4'b0101);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_vld", ret_vld_o, 0);
    checkOutput("async_rst_pend", pend_o, 0);
    checkOutput("async_rst_err", err_o, 0);
    checkOutput("async_rst_rdy", call_rdy_o, 0);
    checkOutput("async_rst_write", cmd_write_o, 0);
    tick();
    tick();
    rst = 1'b0;
    applyStimulus(1, 1, 3, 1, 32'h900, ARGS_C);
    #1;
    checkOutput("post_rst_rdy", call_rdy_o, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h0, '0);
    #1;
    checkOutput("post_rst_pend", pend_o, 4'b0010);
    checkOutput("post_rst_din", cmd_din_o, {32'h0000_0900, 1'b1, 6'd3, 2'd1, ARGS_C});
    tick();
    applyReturn(1, 3, 32'h0BAD_F00D, 1);
    tick();
    applyReturn(0, 0, 32'h0, 1);
    #1;
    checkOutput("post_rst_ret_data", ret_data_o, 32'h0BAD_F00D);
    tick();
    #1;
    checkOutput("post_rst_pend_clear", pend_o, 4'b0000);
    checkOutput("post_rst_err", err_o, 0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parent_call_port.md
PARENT_CALL_PORT -- requirements
Module: parent_call_port

Interface
REQ-001 Parameter THREAD, default 4, number of hardware threads sharing this parent port.
REQ-002 Parameter CHILD, default 64, number of callable child functions.
REQ-003 Parameters ARG_W, default 32, and ARG_NUM, default 4: argument width and count; LOG_THREAD = max(1, clog2 THREAD); LOG_CHILD = max(1, clog2 CHILD); RET_DW = 32; CMD_DW = ARG_W*ARG_NUM + LOG_THREAD + LOG_CHILD + 1 + 32.
REQ-004 Clocking: one clock; reset is asynchronous and active-high; ports are clk and rst.
REQ-005 clk  in  1  clock, all state on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 call_vld_i  in  1  parent issues a call.
REQ-008 call_rdy_o  out  1  call accepted when call_vld_i and call_rdy_o are both high.
REQ-009 call_thread_i  in  LOG_THREAD  issuing thread; call_child_i  in  LOG_CHILD  target child; call_ret_i  in  1  return value expected.
REQ-010 call_pc_i  in  32  caller pc; call_args_i  in  ARG_NUM*ARG_W  packed arguments.
REQ-011 cmd_din_o  out  CMD_DW  command word to the arbiter; cmd_write_o  out  1  write strobe; cmd_full_n_i  in  1  arbiter command slot free.
REQ-012 ret_empty_n_i  in  1  return FIFO non-empty; ret_dout_i  in  RET_DW+LOG_CHILD  {child, data}, first-word-fall-through; ret_pop_o  out  1  pop.
REQ-013 ret_vld_o  out  1, ret_rdy_i  in  1, ret_thread_o  out  LOG_THREAD, ret_data_o  out  32: delivered return to the parent.
REQ-014 pend_o  out  THREAD  per-thread outstanding-return flags; err_o  out  1  sticky unmatched-return flag.

Function
REQ-015 Command word, MSB to LSB: pc[31:0], ret flag, child, thread, args.
REQ-016 One-entry command register: an accepted call loads it in cycle N; cmd_write_o asserts from N+1 while the register is valid and cmd_full_n_i is high.
REQ-017 cmd_write_o = cmd_vld and cmd_full_n_i; the register empties on a write unless refilled in the same cycle.
REQ-018 call_rdy_o = (not cmd_vld or cmd_full_n_i) and not hazard; back-to-back calls at 1 per cycle when the arbiter never stalls.
REQ-019 hazard, for a call with call_ret_i=1: pend[call_thread_i] set, or any pending thread whose stored child equals call_child_i; calls with call_ret_i=0 see no hazard.
REQ-020 Hazard evaluation uses registered pend state; a return cleared in cycle N permits a hazarded call from cycle N+1.
REQ-021 Pending table per thread: pend flag and child index; set on acceptance of a call with call_ret_i=1; cleared when that thread's return is delivered (ret_vld_o and ret_rdy_i).
REQ-022 ret_pop_o = ret_empty_n_i and (not ret_vld_o or ret_rdy_i); the popped word is taken in the same cycle.
REQ-023 On pop, match the popped child against pending entries (the unique pend thread with equal child); on a hit, load ret_thread_o/ret_data_o and assert ret_vld_o from the next cycle.
REQ-024 On pop with no match: word dropped, ret_vld_o unchanged (low), err_o set and held until reset.
REQ-025 Outputs ret_thread_o/ret_data_o hold stable while ret_vld_o is high and ret_rdy_i is low.
REQ-026 A delivery and a new pop in the same cycle are permitted: the old entry is cleared, the new entry loads, and ret_vld_o stays high.
REQ-027 Set and clear of the same pend entry in one cycle cannot occur (hazard rule); set and clear on different threads in one cycle both take effect.
REQ-028 pend_o is the registered pend flag vector.

Reset
REQ-029 While rst is high: cmd_vld, pend flags, pend children, ret_vld_o, err_o, cmd_write_o and ret_pop_o are 0, and call_rdy_o is 0.
REQ-030 Reset mid-operation discards the command register, the pending table and the return register; a partially delivered return is lost.
REQ-031 The first call is accepted in the first cycle after rst deasserts.

Verification
REQ-032 Call thread 1, child 5, ret=1, pc 0x100, with cmd_full_n_i=1 -> cmd_write_o high one cycle later with the correct packing, and pend_o=0b0010.
REQ-033 cmd_full_n_i held low for 3 cycles with two calls offered -> the first call is held, call_rdy_o is low, and both writes occur in order after release.
REQ-034 Thread 0 pending on child 5; thread 2 calls child 5 with ret=1 -> call_rdy_o stays low until thread 0's return is delivered, then the call is accepted the next cycle.
REQ-035 Return word {child 5, 0xDEADBEEF} with thread 0 pending on child 5 and ret_rdy_i low for 2 cycles -> ret_vld_o high, thread 0, data stable; pend_o[0] clears after the handshake.
REQ-036 Return word for child 9 with no matching pending entry -> the word is popped, no ret_vld_o, and err_o stays 1 until rst.
REQ-037 rst asserted while ret_vld_o=1 and pend_o=0b0101 -> all outputs 0 immediately (async); normal operation after release.
